touch_packet_decoder: RTL and testbench

TOUCH_PACKET_DECODER -- requirements
Module: touch_packet_decoder

---
 rtl/touch_packet_decoder.sv | 130 +++++++++++++
 tb/tb_touch_packet_decoder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/touch_packet_decoder.sv
// Touchscreen UART packet decoder: 5-byte header/X/Y packets
// to a held touch event with framing, timeout and overflow flags.
module touch_packet_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        event_valid,
  input  logic        event_ready,
  output logic        event_pen_down,
  output logic [11:0] event_x,
  output logic [11:0] event_y,
  output logic        frame_error,
  output logic        overflow
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, X_LO, X_HI, Y_LO, Y_HI
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_pen;
  logic [6:0]    r_xlo;
  logic [4:0]    r_xhi;
  logic [6:0]    r_ylo;
  logic          w_hdr;
  logic          w_data;
  logic          w_ctl;
  logic          w_tmo;
  logic          w_ferr;
  logic          w_done;

  assign w_hdr  = rx_valid && (rx_data[7:1] == 7'h40);
  assign w_data = rx_valid && !rx_data[7];
  assign w_ctl  = rx_valid && rx_data[7];
  // A byte arriving on the limit cycle suppresses the timeout
  assign w_tmo  = (r_state != IDLE) && !rx_valid &&
                  (r_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_next = r_state;
    w_ferr = 1'b0;
    w_done = 1'b0;
    if (r_state == IDLE) begin
      if (w_hdr)
        w_next = X_LO;
      else if (w_ctl)
        w_ferr = 1'b1;
    end else if (w_ctl) begin
      w_ferr = 1'b1;
      w_next = w_hdr ? X_LO : IDLE;
    end else if (w_data) begin
      case (r_state)
        X_LO:    w_next = X_HI;
        X_HI:    w_next = Y_LO;
        Y_LO:    w_next = Y_HI;
        Y_HI: begin
          w_next = IDLE;
          w_done = 1'b1;
        end
        default: w_next = IDLE;
      endcase
    end else if (w_tmo) begin
      w_next = IDLE;
      w_ferr = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (rx_valid || r_state == IDLE || w_tmo)
        r_cnt <= '0;
      else
        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pen <= 1'b0;
      r_xlo <= '0;
      r_xhi <= '0;
      r_ylo <= '0;
    end else begin
      if (w_hdr)
        r_pen <= rx_data[0];
      if (w_data) begin
        case (r_state)
          X_LO:    r_xlo <= rx_data[6:0];
          X_HI:    r_xhi <= rx_data[4:0];
          Y_LO:    r_ylo <= rx_data[6:0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      event_valid    <= 1'b0;
      event_pen_down <= 1'b0;
      event_x        <= '0;
      event_y        <= '0;
      frame_error    <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      frame_error <= w_ferr;
      overflow    <= w_done && event_valid && !event_ready;
      if (w_done) begin
        event_valid    <= 1'b1;
        event_pen_down <= r_pen;
        event_x        <= {r_xhi, r_xlo};
        event_y        <= {rx_data[4:0], r_ylo};
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_touch_packet_decoder.sv
// Scoreboard bench for touch_packet_decoder: expected events
// queued at stimulus time, compared on each consumed event.
module tb_touch_packet_decoder;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        event_valid;
  logic        event_ready = 1'b0;
  logic        event_pen_down;
  logic [11:0] event_x;
  logic [11:0] event_y;
  logic        frame_error;
  logic        overflow;

  int vec_cnt = 0;
  int err_cnt = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int ev_cnt = 0;
  int fe0, ov0, ev0;
  logic [24:0] exp_q[$];

  touch_packet_decoder #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .event_valid    (event_valid),
    .event_ready    (event_ready),
    .event_pen_down (event_pen_down),
    .event_x        (event_x),
    .event_y        (event_y),
    .frame_error    (frame_error),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic pkt(input logic [7:0] h, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] c,
                     input logic [7:0] d);
    send(h); send(a); send(b); send(c); send(d);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ev"}, 32'(event_valid), 0);
    chk({tag, "_xy"}, {event_pen_down, event_x, event_y}, 0);
    chk({tag, "_fo"}, {frame_error, overflow}, 0);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (frame_error) fe_cnt++;
      if (overflow) ov_cnt++;
      if (event_valid && event_ready) begin
        ev_cnt++;
        if (exp_q.size() == 0)
          chk("unexp_ev", 1, 0);
        else
          chk("event", {event_pen_down, event_x, event_y},
              32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    #12;
    chk_zero("rst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    idle(1);

    // basic decode, latency 1
    event_ready = 1'b1;
    exp_q.push_back({1'b1, 12'h934, 12'h7FF});
    pkt(8'h81, 8'h34, 8'h12, 8'h7F, 8'h0F);
    chk("lat_ev", 32'(event_valid), 1);
    chk("lat_xy", {event_pen_down, event_x, event_y},
        {7'd0, 1'b1, 12'h934, 12'h7FF});
    idle(2);
    chk("drop_ev", 32'(event_valid), 0);

    // abort by new header
    fe0 = fe_cnt;
    exp_q.push_back({1'b1, 12'h101, 12'h203});
    send(8'h80); send(8'h10);
    pkt(8'h81, 8'h01, 8'h02, 8'h03, 8'h04);
    idle(2);
    chk("abort_fe", fe_cnt - fe0, 1);

    // inter-byte timeout
    fe0 = fe_cnt;
    ev0 = ev_cnt;
    send(8'h81); send(8'h05);
    idle(T - 2);
    chk("tmo_early", fe_cnt - fe0, 0);
    idle(6);
    chk("tmo_fe", fe_cnt - fe0, 1);
    send(8'h05);
    idle(4);
    chk("tmo_resync_fe", fe_cnt - fe0, 1);
    chk("tmo_no_ev", ev_cnt - ev0, 0);

    // overflow keeps newest
    event_ready = 1'b0;
    ov0 = ov_cnt;
    pkt(8'h80, 8'h05, 8'h01, 8'h06, 8'h02);
    chk("ov_a", {event_pen_down, event_x, event_y},
        {7'd0, 1'b0, 12'h085, 12'h106});
    pkt(8'h81, 8'h7F, 8'h7F, 8'h00, 8'h60);
    idle(2);
    chk("ov_cnt", ov_cnt - ov0, 1);
    chk("ov_held", {event_pen_down, event_x, event_y},
        {7'd0, 1'b1, 12'hFFF, 12'h000});
    exp_q.push_back({1'b1, 12'hFFF, 12'h000});
    event_ready = 1'b1;
    idle(2);
    event_ready = 1'b0;

    // completion coincides with handshake
    ov0 = ov_cnt;
    pkt(8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_q.push_back({1'b0, 12'h000, 12'h000});
    exp_q.push_back({1'b1, 12'hAAA, 12'h555});
    send(8'h81); send(8'h2A); send(8'h15); send(8'h55);
    event_ready = 1'b1;
    send(8'h0A);
    chk("same_ev", 32'(event_valid), 1);
    idle(2);
    chk("same_ov", ov_cnt - ov0, 0);

    // bad header then data byte in IDLE
    fe0 = fe_cnt;
    ev0 = ev_cnt;
    send(8'hFF); send(8'h22);
    idle(3);
    chk("ff22_fe", fe_cnt - fe0, 1);
    chk("ff22_ev", ev_cnt - ev0, 0);

    // reset mid-packet with an event held
    event_ready = 1'b0;
    pkt(8'h81, 8'h11, 8'h01, 8'h22, 8'h02);
    chk("pre_rst_ev", 32'(event_valid), 1);
    fe0 = fe_cnt;
    send(8'h81); send(8'h10);
    reset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    idle(3);
    reset_n = 1'b1;
    event_ready = 1'b1;
    exp_q.push_back({1'b1, 12'h001, 12'h002});
    pkt(8'h81, 8'h01, 8'h00, 8'h02, 8'h00);
    chk("post_rst_ev", 32'(event_valid), 1);
    idle(3);
    chk("post_rst_fe", fe_cnt - fe0, 0);
    chk("q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
